// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button/switch input conditioner.
package btn_pkg;

   localparam int unsigned N_BTN = 5;

   localparam int unsigned BTN_CENTER = 0;
   localparam int unsigned BTN_TOP    = 1;
   localparam int unsigned BTN_BOTTOM = 2;
   localparam int unsigned BTN_LEFT   = 3;
   localparam int unsigned BTN_RIGHT  = 4;

   // 10 ms at 100 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

   // Debounce state is implied by comparing the synchronized input with the level
   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_e;

endpackage

// File: rtl/debounce_cell.sv
// One button: two-flop synchronizer, stability counter and debounced level register.
// rise is combinational and flags the edge on which level goes 0->1.
module debounce_cell
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta;
   logic             sync_s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             level_next;
   db_state_e        state_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_s    <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync_s    <= sync_meta;
      end
   end

   // Counter only runs while the input disagrees with the level; clears at expiry
   always_comb begin
      state_c    = DB_STABLE;
      cnt_next   = '0;
      level_next = level;
      rise       = 1'b0;
      if (sync_s != level) begin
         state_c = DB_PENDING;
      end
      case (state_c)
         DB_STABLE: begin
            cnt_next = '0;
         end
         DB_PENDING: begin
            if (cnt == CNT_LAST) begin
               level_next = sync_s;
               cnt_next   = '0;
               rise       = sync_s;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         level <= level_next;
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Input conditioning for the card-game FSM: synchronized switches, debounced buttons
// and one-hot press pulses with chord lockout.
module btn_conditioner #(
   parameter int unsigned N_BTN           = btn_pkg::N_BTN,
   parameter int unsigned SW_WIDTH        = 16,
   parameter int unsigned DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_BTN-1:0]    btn_raw,
   input  logic [SW_WIDTH-1:0] sw_raw,
   output logic [N_BTN-1:0]    btn_level,
   output logic [N_BTN-1:0]    btn_pulse,
   output logic [SW_WIDTH-1:0] sw_sync
);

   logic [N_BTN-1:0]    rise_c;
   logic [N_BTN-1:0]    pulse_next_c;
   logic                lock_c;
   logic [SW_WIDTH-1:0] sw_meta;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .rise  (rise_c[i])
      );
   end

   // Any button already down locks out new presses; simultaneous rises keep the lowest index
   always_comb begin
      lock_c       = |btn_level;
      pulse_next_c = '0;
      if (!lock_c) begin
         pulse_next_c = rise_c & (~rise_c + N_BTN'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_pulse <= '0;
      end else begin
         btn_pulse <= pulse_next_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_raw;
         sw_sync <= sw_meta;
      end
   end

endmodule
